instr_fetch_unit: RTL

Producer side of the instruction interface that feeds the decode/control block. It issues word fetches to instruction memory over a req/ack handshake and buffers returned words in a small prefetch queue. It presents one instruction at a time with its PC over a valid/ready handshake. It accepts branch redirects from decode, flushing stale prefetched words and restarting at the computed ARM branch target.

---
 rtl/instr_fetch_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: req/ack word fetcher with a DEPTH-entry prefetch queue and branch redirect.
// Optional performance counters are enabled by defining IFU_PERF_EN.
module instr_fetch_unit #(
    parameter int unsigned DEPTH        = 2,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_code,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    input  logic [23:0] branch_offset
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_flushed
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;

    ptr_t        rd_ptr_q, wr_ptr_q, next_rd;
    cnt_t        count_q, cnt_popped, cnt_after;
    logic [31:0] code_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] head_code_q, head_code_d;
    logic [31:0] head_pc_q, head_pc_d;

    logic        pop, push;
    logic [31:0] target;

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_code  = head_code_q;
    assign instr_pc    = head_pc_q;

    always_comb begin
        pop        = (count_q != '0) && instr_ready;
        push       = (state_q == REQ) && mem_ack && !branch_taken;
        cnt_popped = count_q - cnt_t'(pop);
        cnt_after  = cnt_popped + cnt_t'(push);
        next_rd    = rd_ptr_q + ptr_t'(pop);
        target     = branch_pc + 32'd8 + {{6{branch_offset[23]}}, branch_offset, 2'b00};
    end

    // Fetch FSM; a branch overrides whatever the state would otherwise do.
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;

        case (state_q)
            IDLE: begin
                if (cnt_popped < DEPTH_C) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (cnt_after < DEPTH_C) begin
                        mem_addr_d = fetch_pc_q + 32'd4;
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (branch_taken) begin
            fetch_pc_d = target;
            if (state_q != IDLE && !mem_ack) begin
                state_d    = DISCARD;
                mem_req_d  = 1'b1;
                mem_addr_d = mem_addr_q;
            end else begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_VECTOR;
            fetch_pc_q <= RESET_VECTOR;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Head registers hold the last delivered entry while the queue is empty.
    always_comb begin
        head_code_d = head_code_q;
        head_pc_d   = head_pc_q;
        if (!branch_taken && cnt_after != '0) begin
            if (cnt_popped == '0) begin
                head_code_d = mem_rdata;
                head_pc_d   = mem_addr_q;
            end else begin
                head_code_d = code_q[next_rd];
                head_pc_d   = pc_q[next_rd];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            head_code_q <= '0;
            head_pc_q   <= '0;
        end else begin
            head_code_q <= head_code_d;
            head_pc_q   <= head_pc_d;
            if (branch_taken) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
                if (pop)  rd_ptr_q <= next_rd;
                count_q <= cnt_after;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            code_q[wr_ptr_q] <= mem_rdata;
            pc_q[wr_ptr_q]   <= mem_addr_q;
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [15:0] perf_flushed_q;
    logic [16:0] flush_sum;

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;

    // A branch in REQ always drops the outstanding word, acked or not.
    always_comb begin
        flush_sum = {1'b0, perf_flushed_q} + 17'(cnt_popped) + 17'(state_q == REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (mem_req_q && mem_ack && perf_fetched_q != '1) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (branch_taken) begin
                perf_flushed_q <= flush_sum[16] ? '1 : flush_sum[15:0];
            end
        end
    end
`endif

endmodule
